// File: rtl/trojan_pkg.sv
// Shared types and widths for the key-path trojan monitor.
// Holds the key/trigger widths and the monitor FSM state encoding.
package trojan_pkg;

  localparam int KEY_W  = 56;
  localparam int TRIG_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATCH = 2'd1,
    ALARM = 2'd2
  } state_e;

endpackage

// File: rtl/trojan_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// nxt_o exposes the saturated increment so callers can look ahead.
module trojan_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturated increment of the current count.
  always_comb begin
    nxt_o = cnt_q;
    if (cnt_q != MAX) nxt_o = cnt_q + 1'b1;
  end

  // Clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = nxt_o;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trojan_monitor.sv
// Counts key/payload mismatches and raises an alarm at THRESHOLD.
// Define TROJAN_MONITOR_LOG_EN to build the diff_mask/last_trigger logs.
module trojan_monitor
  import trojan_pkg::*;
#(
  parameter int THRESHOLD = 3,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key,
  input  logic [KEY_W-1:0]  payload,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              valid,
  input  logic              alarm_ack,
  output logic              alarm,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [KEY_W-1:0]  diff_mask,
  output logic [TRIG_W-1:0] last_trigger
);

  state_e           state_q;
  state_e           state_d;
  logic             mism;
  logic             cnt_clr;
  logic             cnt_en;
  logic             log_en;
  logic [CNT_W-1:0] cnt_nxt;

  assign mism = valid && (payload != key);

  trojan_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (mismatch_count),
    .nxt_o (cnt_nxt)
  );

  // Next state: acknowledge beats a same-edge mismatch.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    log_en  = 1'b0;
    if (alarm_ack) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (mism) begin
      cnt_en = 1'b1;
      log_en = 1'b1;
      case (state_q)
        IDLE, WATCH: begin
          if (32'(cnt_nxt) >= THRESHOLD) state_d = ALARM;
          else                           state_d = WATCH;
        end
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign alarm = (state_q == ALARM);

`ifdef TROJAN_MONITOR_LOG_EN
  logic [KEY_W-1:0]  diff_q;
  logic [TRIG_W-1:0] trig_q;

  // Capture the most recent accepted mismatching sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      trig_q <= '0;
    end else if (log_en) begin
      diff_q <= payload ^ key;
      trig_q <= trigger;
    end
  end

  assign diff_mask    = diff_q;
  assign last_trigger = trig_q;
`else
  logic unused_log;
  assign unused_log   = log_en ^ (^trigger);
  assign diff_mask    = '0;
  assign last_trigger = '0;
`endif

endmodule

// File: tb/tb_trojan_monitor.sv
// Bench for trojan_monitor: default instance plus THRESHOLD=1/CNT_W=2.
// Table vectors, a reset corner sequence and random traffic vs a model.
module tb_trojan_monitor;

  localparam logic [55:0] K = 56'h00_1234_5678_9ABC;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] key;
  logic [55:0] payload;
  logic [31:0] trigger;
  logic        valid;
  logic        alarm_ack;

  logic        alm0, alm1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic [55:0] dm0, dm1;
  logic [31:0] lt0, lt1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trojan_monitor dut0 (
    .clk(clk), .rst(rst), .key(key), .payload(payload),
    .trigger(trigger), .valid(valid), .alarm_ack(alarm_ack),
    .alarm(alm0), .mismatch_count(cnt0),
    .diff_mask(dm0), .last_trigger(lt0)
  );

  trojan_monitor #(.THRESHOLD(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .key(key), .payload(payload),
    .trigger(trigger), .valid(valid), .alarm_ack(alarm_ack),
    .alarm(alm1), .mismatch_count(cnt1),
    .diff_mask(dm1), .last_trigger(lt1)
  );

  // Behavioural reference: counts, thresholds and last-mismatch log.
  int          m_cnt[2];
  int          m_max[2] = '{255, 3};
  int          m_thr[2] = '{3, 1};
  logic [55:0] m_diff;
  logic [31:0] m_trig;

  function automatic logic [55:0] lg56(input logic [55:0] v);
`ifdef TROJAN_MONITOR_LOG_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic logic [31:0] lg32(input logic [31:0] v);
`ifdef TROJAN_MONITOR_LOG_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic void model_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_diff = '0;
    m_trig = '0;
  endfunction

  function automatic void model_edge();
    bit mm;
    mm = valid && (payload != key);
    for (int i = 0; i < 2; i++) begin
      if (alarm_ack)  m_cnt[i] = 0;
      else if (mm)    m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
    end
    if (!alarm_ack && mm) begin
      m_diff = payload ^ key;
      m_trig = trigger;
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt0"}, 64'(cnt0), 64'(m_cnt[0]));
    chk({tag, ".alm0"}, 64'(alm0), 64'(m_cnt[0] >= m_thr[0]));
    chk({tag, ".cnt1"}, 64'(cnt1), 64'(m_cnt[1]));
    chk({tag, ".alm1"}, 64'(alm1), 64'(m_cnt[1] >= m_thr[1]));
    chk({tag, ".dm0"},  64'(dm0),  64'(lg56(m_diff)));
    chk({tag, ".lt0"},  64'(lt0),  64'(lg32(m_trig)));
    chk({tag, ".dm1"},  64'(dm1),  64'(lg56(m_diff)));
    chk({tag, ".lt1"},  64'(lt1),  64'(lg32(m_trig)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        v;
    logic        ack;
    logic [55:0] x;
    logic [31:0] trg;
    int          c0;
    logic        a0;
    int          c1;
    logic        a1;
    logic [55:0] dm;
    logic [31:0] lt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 56'h1, 32'd0,  1, 0, 1, 1, 56'h1, 32'd0};
    tbl[1]  = '{1, 0, 56'h1, 32'd16, 2, 0, 2, 1, 56'h1, 32'd16};
    tbl[2]  = '{1, 0, 56'h1, 32'd32, 3, 1, 3, 1, 56'h1, 32'd32};
    tbl[3]  = '{1, 1, 56'h2, 32'd7,  0, 0, 0, 0, 56'h1, 32'd32};
    tbl[4]  = '{0, 0, 56'h3, 32'd9,  0, 0, 0, 0, 56'h1, 32'd32};
    tbl[5]  = '{1, 0, 56'h0, 32'd9,  0, 0, 0, 0, 56'h1, 32'd32};
    tbl[6]  = '{1, 0, 56'h4, 32'd1,  1, 0, 1, 1, 56'h4, 32'd1};
    tbl[7]  = '{1, 0, 56'h4, 32'd2,  2, 0, 2, 1, 56'h4, 32'd2};
    tbl[8]  = '{1, 0, 56'h4, 32'd3,  3, 1, 3, 1, 56'h4, 32'd3};
    tbl[9]  = '{1, 0, 56'h4, 32'd4,  4, 1, 3, 1, 56'h4, 32'd4};
    tbl[10] = '{1, 0, 56'h4, 32'd5,  5, 1, 3, 1, 56'h4, 32'd5};
    tbl[11] = '{0, 1, 56'h0, 32'd0,  0, 0, 0, 0, 56'h4, 32'd5};

    rst = 1'b1;
    key = K;
    payload = K;
    trigger = '0;
    valid = 1'b0;
    alarm_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk_model("reset");
    @(negedge clk);
    rst = 1'b0;

    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      trigger = 32'(i);
      tick();
    end
    chk_model("match10");

    for (int i = 0; i < 12; i++) begin
      valid = tbl[i].v;
      alarm_ack = tbl[i].ack;
      payload = K ^ tbl[i].x;
      trigger = tbl[i].trg;
      tick();
      chk($sformatf("t%0d.cnt0", i), 64'(cnt0), 64'(tbl[i].c0));
      chk($sformatf("t%0d.alm0", i), 64'(alm0), 64'(tbl[i].a0));
      chk($sformatf("t%0d.cnt1", i), 64'(cnt1), 64'(tbl[i].c1));
      chk($sformatf("t%0d.alm1", i), 64'(alm1), 64'(tbl[i].a1));
      chk($sformatf("t%0d.dm0", i), 64'(dm0), 64'(lg56(tbl[i].dm)));
      chk($sformatf("t%0d.lt0", i), 64'(lt0), 64'(lg32(tbl[i].lt)));
    end

    valid = 1'b1;
    alarm_ack = 1'b0;
    payload = K ^ 56'h8;
    trigger = 32'hAB;
    tick();
    tick();
    chk("pre_rst.cnt0", 64'(cnt0), 64'd2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk_model("async_rst");
    rst = 1'b0;
    tick();
    chk("post_rst.cnt0", 64'(cnt0), 64'd1);
    chk("post_rst.alm0", 64'(alm0), 64'd0);
    chk("post_rst.cnt1", 64'(cnt1), 64'd1);
    chk_model("post_rst");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) key = {$urandom, $urandom};
      valid = ($urandom_range(0, 3) != 0);
      alarm_ack = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) payload = key;
      else payload = key ^ (56'h1 << $urandom_range(0, 55));
      trigger = $urandom;
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trojan_monitor.md
TROJAN_MONITOR -- requirements
Module: trojan_monitor

Interface
REQ-001 Parameter THRESHOLD, default 3: mismatching samples that raise the alarm; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of mismatch_count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 key  input  56  golden key from the key schedule source.
REQ-006 payload  input  56  key as delivered downstream of a possibly tampered path.
REQ-007 trigger  input  32  trigger word presented alongside the sample.
REQ-008 valid  input  1  sample strobe; key/payload/trigger are examined only when valid=1.
REQ-009 alarm_ack  input  1  software acknowledge; clears the alarm and the count.
REQ-010 alarm  output  1  high while in state ALARM.
REQ-011 mismatch_count  output  CNT_W  mismatching samples since the last clear.
REQ-012 diff_mask  output  56  payload XOR key of the most recent mismatching sample.
REQ-013 last_trigger  output  32  trigger of the most recent mismatching sample.

Function
REQ-014 A sample SHALL be a mismatch when valid=1 and payload != key (any bit differs).
REQ-015 FSM states SHALL be IDLE (count=0), WATCH (0<count<THRESHOLD) and ALARM (count>=THRESHOLD).
REQ-016 IDLE/WATCH: a mismatch SHALL increment the count on that edge, with next state WATCH, or ALARM if the new count >= THRESHOLD.
REQ-017 A matching sample or valid=0 SHALL leave the state and all outputs unchanged.
REQ-018 Latency: a mismatch sampled at edge N SHALL be visible on mismatch_count/alarm/diff_mask/last_trigger after edge N (1 cycle); all outputs registered.
REQ-019 ALARM: further mismatches SHALL keep incrementing the count and updating the logs; alarm stays 1.
REQ-020 mismatch_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 alarm_ack=1 in ALARM SHALL go to IDLE, clear the count to 0 and drop alarm after that edge; diff_mask/last_trigger are retained.
REQ-022 alarm_ack with valid mismatch on the same edge SHALL take precedence; that sample SHALL be discarded.
REQ-023 alarm_ack in IDLE or WATCH SHALL clear the count to 0 and go to IDLE.
REQ-024 THRESHOLD=1 SHALL go IDLE->ALARM on the first mismatch.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, alarm=0, mismatch_count=0, diff_mask=0, last_trigger=0.
REQ-026 Reset mid-sequence SHALL discard all accumulated counts; the first edge after deassertion behaves as from IDLE.

Configuration
REQ-027 Macro TROJAN_MONITOR_LOG_EN defined: diff_mask and last_trigger SHALL be implemented per REQ-012/013/019.
REQ-028 Macro undefined: diff_mask and last_trigger SHALL be constant 0, with no log registers built; FSM and count behave identically.

Structure
REQ-029 Shared package trojan_pkg SHALL hold KEY_W=56, TRIG_W=32 and the FSM state enum (IDLE, WATCH, ALARM).
REQ-030 One sub-module, trojan_sat_counter (saturating up-counter with synchronous clear and enable), SHALL implement mismatch_count.

Verification
REQ-031 Reset, then 10 valid samples with payload==key=56'h00_1234_5678_9ABC -> count 0, alarm 0, state IDLE.
REQ-032 Three mismatches with payload=key^56'h1, triggers 0, 16, 32 -> count 1,2,3; alarm=1 one cycle after the third; diff_mask=56'h1, last_trigger=32.
REQ-033 In ALARM, alarm_ack=1 with a valid mismatch on the same edge -> count 0, alarm 0, IDLE; logs unchanged.
REQ-034 THRESHOLD=1, CNT_W=2: 5 mismatches -> alarm after the first; count 1,2,3,3,3 (saturates).
REQ-035 Two mismatches, then rst pulsed between edges -> outputs 0 immediately; next mismatch gives count 1, state WATCH.
REQ-036 Build without TROJAN_MONITOR_LOG_EN, rerun REQ-032 -> identical count/alarm; diff_mask=0, last_trigger=0 throughout.
